// File: rtl/response_capture_pkg.sv
// response_capture shared package
// FSM state encoding and pointer/count width helpers
package response_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: DEPTH x DATA_W sample store
// synchronous write port, registered synchronous read port
module capture_ram
    import response_capture_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_w(DEPTH)-1:0]    waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [ptr_w(DEPTH)-1:0]    raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // storage is never reset; read register holds until next read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/response_capture.sv
// response_capture: samples DIN every SAMPLE_DIV cycles into DEPTH slots
// then drains them one per RD_EN through a registered valid/data pair
module response_capture
    import response_capture_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter int DEPTH      = 32,
    parameter int SAMPLE_DIV = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic                     CLEAR,
    input  logic [DATA_W-1:0]        DIN,
    input  logic                     RD_EN,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic                     RD_VALID,
    output logic                     BUSY,
    output logic                     FULL,
    output logic [cnt_w(DEPTH)-1:0]  COUNT
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int DIV_W = div_w(SAMPLE_DIV);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DIV_W-1:0]   div;
    logic               rd_end;
    logic               rd_acc;
    logic [DATA_W-1:0]  ram_q;
    logic               sample;
    logic               wr_en;
    logic               rd_req;

    // rd_end marks the last slot drained, since rd_ptr cannot hold DEPTH
    assign sample = (state == CAPTURE) && (div == '0);
    assign wr_en  = sample && !CLEAR;
    assign rd_req = (state == DONE) && RD_EN && !rd_end && !CLEAR;

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (CLK),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (DIN),
        .re    (rd_req),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // control FSM, pointers, divider and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            div      <= '0;
            rd_end   <= 1'b0;
            rd_acc   <= 1'b0;
            RD_DATA  <= '0;
            RD_VALID <= 1'b0;
            BUSY     <= 1'b0;
            FULL     <= 1'b0;
            COUNT    <= '0;
        end else if (CLEAR) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            div      <= '0;
            rd_end   <= 1'b0;
            rd_acc   <= 1'b0;
            RD_VALID <= 1'b0;
            BUSY     <= 1'b0;
            FULL     <= 1'b0;
            COUNT    <= '0;
        end else begin
            RD_VALID <= rd_acc;
            if (rd_acc) begin
                RD_DATA <= ram_q;
            end
            rd_acc <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        state  <= CAPTURE;
                        BUSY   <= 1'b1;
                        COUNT  <= '0;
                        div    <= '0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        rd_end <= 1'b0;
                    end
                end
                CAPTURE: begin
                    div <= (div == DIV_LAST) ? '0 : div + 1'b1;
                    if (sample) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        COUNT  <= COUNT + 1'b1;
                        if (wr_ptr == LAST) begin
                            state <= DONE;
                            BUSY  <= 1'b0;
                            FULL  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (rd_req) begin
                        rd_acc <= 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == LAST) begin
                            rd_end <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
